// File: rtl/mux_scan_n_1.sv
// -----------------------------------------------------------------------------
// mux_scan_n_1
//
// Registered N:1 multiplexer. Picks one WIDTH-bit channel out of CHANNELS
// flattened channels, either from an external select (DIRECT), from an
// internal scanner that dwells DWELL enabled cycles per channel (SCAN), or
// keeps its output frozen (HOLD / reserved mode).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   en       clock enable, 0 freezes all state (wrap reads 0)
//   mode     00 DIRECT, 01 SCAN, 10 HOLD, 11 reserved (behaves as HOLD)
//   sel      channel select used in DIRECT mode
//   din      channel k at din[k*WIDTH +: WIDTH]
//   y        registered data of the channel in cur_sel
//   cur_sel  channel index that y currently reflects
//   valid    y comes from an in-range channel
//   wrap     one-cycle pulse when the scanner returns to channel 0
//
// All outputs are registered; y and cur_sel are always loaded together from
// the same next_sel, so they stay coherent.
// -----------------------------------------------------------------------------
module mux_scan_n_1 #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 1,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          cur_sel,
    output logic                      valid,
    output logic                      wrap
);

    localparam int               SLOTS    = 1 << SEL_W;
    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [1:0]       MODE_DIRECT = 2'b00;
    localparam logic [1:0]       MODE_SCAN   = 2'b01;

    // Channel table padded to the full select range: unused slots read as
    // zero and are flagged out of range, so any select value is safe to use.
    logic [WIDTH-1:0] slot_data [SLOTS];
    logic             slot_ok   [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
            if (gi < CHANNELS) begin : g_live
                assign slot_data[gi] = din[gi*WIDTH +: WIDTH];
                assign slot_ok[gi]   = 1'b1;
            end else begin : g_pad
                assign slot_data[gi] = '0;
                assign slot_ok[gi]   = 1'b0;
            end
        end
    endgenerate

    logic [SEL_W-1:0] cur_sel_reg, sel_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] y_reg;
    logic             valid_reg;
    logic             wrap_reg, wrap_next;
    logic             update;

    always_comb begin
        sel_next  = cur_sel_reg;
        cnt_next  = cnt_reg;
        wrap_next = 1'b0;
        update    = 1'b0;
        if (en) begin
            case (mode)
                MODE_DIRECT: begin
                    update   = 1'b1;
                    sel_next = sel;
                    cnt_next = '0;
                end
                MODE_SCAN: begin
                    update = 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next = '0;
                        // Last channel, or an out-of-range index left over
                        // from DIRECT, both restart the scan at channel 0.
                        if (cur_sel_reg >= SEL_LAST) begin
                            sel_next  = '0;
                            wrap_next = 1'b1;
                        end else begin
                            sel_next = cur_sel_reg + SEL_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: ;  // HOLD and reserved: everything stays put
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_sel_reg <= '0;
            cnt_reg     <= '0;
            y_reg       <= '0;
            valid_reg   <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            wrap_reg <= wrap_next;
            if (update) begin
                cur_sel_reg <= sel_next;
                cnt_reg     <= cnt_next;
                // Refreshed every active cycle so din changes on the current
                // channel show up one cycle later. valid follows the channel
                // range, so a scan still dwelling on an out-of-range index
                // keeps reporting y as not valid.
                y_reg       <= slot_data[sel_next];
                valid_reg   <= slot_ok[sel_next];
            end
        end
    end

    assign y       = y_reg;
    assign cur_sel = cur_sel_reg;
    assign valid   = valid_reg;
    assign wrap    = wrap_reg;

endmodule
